// File: rtl/radiation_replay_pkg.sv
// ============================================================================
// radiation_replay_pkg
// Shared types and helpers for the radiation replay engine.
//   state_e      : replay FSM states
//   field_e      : selects one field of a packed {delay, channel, value} word
//   ch_width     : channel field width, at least one bit
//   word_width   : total packed word width
//   unpack_field : extracts one field of a packed word (fields up to 64 bits)
// ============================================================================
package radiation_replay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_PRESENT = 3'd4,
        ST_STARVED = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FLD_VALUE   = 2'd0,
        FLD_CHANNEL = 2'd1,
        FLD_DELAY   = 2'd2
    } field_e;

    function automatic int ch_width(input int num_ch);
        if (num_ch > 1) return $clog2(num_ch);
        else            return 1;
    endfunction

    function automatic int word_width(input int value_w, input int ch_w, input int delay_w);
        return delay_w + ch_w + value_w;
    endfunction

    // Word layout is {delay, channel, value} with value in the LSBs.
    function automatic logic [63:0] unpack_field(input logic [63:0] word, input field_e sel,
                                                 input int value_w, input int ch_w,
                                                 input int delay_w);
        int          lsb;
        int          width;
        logic [63:0] mask;
        case (sel)
            FLD_VALUE:   begin lsb = 0;              width = value_w; end
            FLD_CHANNEL: begin lsb = value_w;        width = ch_w;    end
            FLD_DELAY:   begin lsb = value_w + ch_w; width = delay_w; end
            default:     begin lsb = 0;              width = 0;       end
        endcase
        if (width >= 64) mask = {64{1'b1}};
        else             mask = (64'd1 << width) - 64'd1;
        return (word >> lsb) & mask;
    endfunction

endpackage

// File: rtl/radiation_replay_buffer.sv
// ============================================================================
// radiation_replay_buffer
// Circular word buffer: dual-port RAM with wrap-bit pointers.
//   wr_valid_i/wr_data_i : write request; wr_accept_o high when it is taken
//   pop_i                : advance the read pointer (ignored when empty)
//   rd_data_o            : word at the read pointer, one cycle of RAM latency
//   full_o/empty_o       : buffer state; level_o = words held
// ============================================================================
module radiation_replay_buffer #(
    parameter int ADDR_W = 14,
    parameter int WORD_W = 34
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_valid_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_accept_o,
    input  logic              pop_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rd_data_q;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              pop_s;

    // Same address with differing wrap bits means the writer has lapped the reader.
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                         (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign wr_accept_o = wr_valid_i && !full_o;
    assign pop_s       = pop_i && !empty_o;
    assign level_o     = wr_ptr_q - rd_ptr_q;
    assign rd_data_o   = rd_data_q;

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept_o) wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
        else             wr_ptr_d = wr_ptr_q;
        if (pop_s)       rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
        else             rd_ptr_d = rd_ptr_q;
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {(ADDR_W+1){1'b0}};
            rd_ptr_q <= {(ADDR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // RAM write port and registered read port; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_accept_o) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

endmodule

// File: rtl/radiation_replay_engine.sv
// ============================================================================
// radiation_replay_engine
// Replays buffered radiation words after their embedded delay, either to the
// histogram stream (hw_*) or to the PS (ps_*), with refill interrupt.
//   start_i/stop_i        : begin / abort replay (buffer retained on stop)
//   wr_valid_i/wr_data_i  : {delay, channel, value} writes; wr_ready_o = not full
//   load_floor_i          : refill threshold; refill_irq_o level, refill_clr_i clears
//   route_hw_i            : 1 = histogram stream, 0 = PS, sampled per word
//   level_o, count_recv_o, count_sent_o, underrun_count_o : status
//   latency_max_o         : worst presentation latency
// Optional feature macro: RADIATION_REPLAY_TIMER_EN (latency timer; else 0).
// ============================================================================
module radiation_replay_engine
    import radiation_replay_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int VALUE_W = 16,
    parameter int DELAY_W = 16,
    parameter int NUM_CH  = 4,
    parameter int HOLDOFF = 50,
    localparam int CH_W   = ch_width(NUM_CH),
    localparam int WORD_W = word_width(VALUE_W, CH_W, DELAY_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               wr_valid_i,
    input  logic [WORD_W-1:0]  wr_data_i,
    output logic               wr_ready_o,
    input  logic [ADDR_W:0]    load_floor_i,
    output logic               refill_irq_o,
    input  logic               refill_clr_i,
    input  logic               route_hw_i,
    output logic               hw_valid_o,
    input  logic               hw_ready_i,
    output logic [VALUE_W-1:0] hw_value_o,
    output logic [CH_W-1:0]    hw_channel_o,
    output logic               ps_value_ready_o,
    output logic [VALUE_W-1:0] ps_value_o,
    output logic [CH_W-1:0]    ps_channel_o,
    input  logic               ps_ack_i,
    output logic [ADDR_W:0]    level_o,
    output logic [31:0]        count_recv_o,
    output logic [31:0]        count_sent_o,
    output logic [15:0]        underrun_count_o,
    output logic [31:0]        latency_max_o
);

    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               route_q, route_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic [CH_W-1:0]    chan_q, chan_d;
    logic [31:0]        count_recv_q, count_recv_d, count_sent_q, count_sent_d;
    logic [15:0]        underrun_q, underrun_d;
    logic               irq_q, irq_d;
    logic [HO_W-1:0]    holdoff_q, holdoff_d;
    logic               wr_accept_s, pop_s, handshake_s, empty_s, full_s, irq_set_s;
    logic [WORD_W-1:0]  rd_data_s;
    logic [DELAY_W-1:0] load_delay_s;

    radiation_replay_buffer #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_buffer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_valid_i  (wr_valid_i),
        .wr_data_i   (wr_data_i),
        .wr_accept_o (wr_accept_s),
        .pop_i       (pop_s),
        .rd_data_o   (rd_data_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .level_o     (level_o)
    );

    assign load_delay_s = DELAY_W'(unpack_field(64'(rd_data_s), FLD_DELAY, VALUE_W, CH_W, DELAY_W));
    // The route sampled at LOAD picks which handshake retires the word.
    assign handshake_s  = route_q ? hw_ready_i : ps_ack_i;

    // Replay FSM: next state, word capture, pop and underrun accounting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        route_d    = route_q;
        value_d    = value_q;
        chan_d     = chan_q;
        underrun_d = underrun_q;
        pop_s      = 1'b0;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) state_d = ST_FETCH;
                    else         state_d = ST_IDLE;
                end
                ST_FETCH: begin
                    if (empty_s) begin
                        state_d = ST_STARVED;
                        if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
                        else                        underrun_d = underrun_q;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    value_d = VALUE_W'(unpack_field(64'(rd_data_s), FLD_VALUE, VALUE_W, CH_W, DELAY_W));
                    chan_d  = CH_W'(unpack_field(64'(rd_data_s), FLD_CHANNEL, VALUE_W, CH_W, DELAY_W));
                    cnt_d   = load_delay_s;
                    route_d = route_hw_i;
                    if (load_delay_s == {DELAY_W{1'b0}}) state_d = ST_PRESENT;
                    else                                 state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // Counter holds D on the first WAIT cycle; D WAIT cycles in total.
                    cnt_d = cnt_q - DELAY_W'(1);
                    if (cnt_q == DELAY_W'(1)) state_d = ST_PRESENT;
                    else                      state_d = ST_WAIT;
                end
                ST_PRESENT: begin
                    if (handshake_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_PRESENT;
                    end
                end
                ST_STARVED: begin
                    if (!empty_s) state_d = ST_FETCH;
                    else          state_d = ST_STARVED;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Traffic counters, both wrapping modulo 2^32.
    always_comb begin
        count_recv_d = count_recv_q;
        count_sent_d = count_sent_q;
        if (wr_accept_s) count_recv_d = count_recv_q + 32'd1;
        else             count_recv_d = count_recv_q;
        if (pop_s)       count_sent_d = count_sent_q + 32'd1;
        else             count_sent_d = count_sent_q;
    end

    assign irq_set_s = start_i ||
                       ((state_q != ST_IDLE) && (level_o <= load_floor_i) && (count_recv_q != 32'd0));

    // Refill interrupt: clear wins, then hold-off blocks any set.
    always_comb begin
        irq_d     = irq_q;
        holdoff_d = holdoff_q;
        if (refill_clr_i) begin
            irq_d     = 1'b0;
            holdoff_d = HO_W'(HOLDOFF);
        end else if (holdoff_q != {HO_W{1'b0}}) begin
            holdoff_d = holdoff_q - HO_W'(1);
        end else if (irq_set_s) begin
            irq_d = 1'b1;
        end else begin
            irq_d = irq_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {DELAY_W{1'b0}};
            route_q      <= 1'b0;
            value_q      <= {VALUE_W{1'b0}};
            chan_q       <= {CH_W{1'b0}};
            count_recv_q <= 32'd0;
            count_sent_q <= 32'd0;
            underrun_q   <= 16'd0;
            irq_q        <= 1'b0;
            holdoff_q    <= {HO_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            route_q      <= route_d;
            value_q      <= value_d;
            chan_q       <= chan_d;
            count_recv_q <= count_recv_d;
            count_sent_q <= count_sent_d;
            underrun_q   <= underrun_d;
            irq_q        <= irq_d;
            holdoff_q    <= holdoff_d;
        end
    end

`ifdef RADIATION_REPLAY_TIMER_EN
    logic [31:0] timer_q, lat_max_q;

    // Latency timer: counts PRESENT cycles, captures the maximum at handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q   <= 32'd0;
            lat_max_q <= 32'd0;
        end else begin
            if (state_q != ST_PRESENT)     timer_q <= 32'd0;
            else if (timer_q != 32'hFFFF_FFFF) timer_q <= timer_q + 32'd1;
            else                           timer_q <= timer_q;
            if (pop_s && (timer_q > lat_max_q)) lat_max_q <= timer_q;
            else                                lat_max_q <= lat_max_q;
        end
    end
    assign latency_max_o = lat_max_q;
`else
    assign latency_max_o = 32'd0;
`endif

    assign wr_ready_o       = !full_s;
    assign refill_irq_o     = irq_q;
    assign hw_valid_o       = (state_q == ST_PRESENT) && route_q;
    assign ps_value_ready_o = (state_q == ST_PRESENT) && !route_q;
    assign hw_value_o       = value_q;
    assign hw_channel_o     = chan_q;
    assign ps_value_o       = value_q;
    assign ps_channel_o     = chan_q;
    assign count_recv_o     = count_recv_q;
    assign count_sent_o     = count_sent_q;
    assign underrun_count_o = underrun_q;

endmodule

// File: tb/tb_radiation_replay_engine.sv
// Directed bench for radiation_replay_engine with an 8-word buffer.
module tb_radiation_replay_engine;

    localparam int AW = 3;
    localparam int VW = 16;
    localparam int CW = 2;
    localparam int DW = 16;
    localparam int WW = DW + CW + VW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, wr_valid, refill_clr, route_hw, hw_ready, ps_ack;
    logic [WW-1:0] wr_data;
    logic [AW:0]   load_floor;
    logic          wr_ready, refill_irq, hw_valid, ps_value_ready;
    logic [VW-1:0] hw_value, ps_value;
    logic [CW-1:0] hw_channel, ps_channel;
    logic [AW:0]   level;
    logic [31:0]   count_recv, count_sent, latency_max;
    logic [15:0]   underrun_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int log_n = 0;
    logic [VW-1:0] log_val [64];
    logic [CW-1:0] log_ch  [64];
    int            log_cyc [64];

    radiation_replay_engine #(.ADDR_W(AW), .VALUE_W(VW), .DELAY_W(DW), .NUM_CH(4), .HOLDOFF(50)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .load_floor_i(load_floor), .refill_irq_o(refill_irq), .refill_clr_i(refill_clr),
        .route_hw_i(route_hw), .hw_valid_o(hw_valid), .hw_ready_i(hw_ready),
        .hw_value_o(hw_value), .hw_channel_o(hw_channel),
        .ps_value_ready_o(ps_value_ready), .ps_value_o(ps_value), .ps_channel_o(ps_channel),
        .ps_ack_i(ps_ack), .level_o(level), .count_recv_o(count_recv),
        .count_sent_o(count_sent), .underrun_count_o(underrun_count),
        .latency_max_o(latency_max)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every histogram handshake with the cycle it completed in.
    always @(posedge clk) begin
        if (rst_n && hw_valid && hw_ready && log_n < 64) begin
            log_val[log_n] <= hw_value;
            log_ch[log_n]  <= hw_channel;
            log_cyc[log_n] <= cyc;
            log_n          <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_valid = 1'b0; wr_data = '0;
        refill_clr = 1'b0; route_hw = 1'b1; hw_ready = 1'b0; ps_ack = 1'b0;
        load_floor = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic write_word(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic [VW-1:0] v);
        wr_valid = 1'b1;
        wr_data  = {d, c, v};
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start(output int st_cyc);
        st_cyc = cyc;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_log(input int target, input int budget, input string tag);
        int k = 0;
        while (log_n < target && k < budget) begin tick(1); k++; end
        chk(tag, 64'(log_n >= target), 64'd1);
    endtask

    task automatic wait_hw_valid(input int budget, input string tag);
        int k = 0;
        while (!hw_valid && k < budget) begin tick(1); k++; end
        chk(tag, 64'(hw_valid), 64'd1);
    endtask

    initial begin
        int st, st2, base, highs, k;
        logic [VW-1:0] exp_v;

        // Reset state
        do_reset();
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_hw_valid", 64'(hw_valid), 64'd0);
        chk("rst_ps_ready", 64'(ps_value_ready), 64'd0);
        chk("rst_irq", 64'(refill_irq), 64'd0);
        chk("rst_recv", 64'(count_recv), 64'd0);
        chk("rst_underrun", 64'(underrun_count), 64'd0);
        chk("rst_latency", 64'(latency_max), 64'd0);

        // 1: three words, spacing D+3 between handshakes, ends starved
        write_word(16'd0, 2'd0, 16'h0011);
        write_word(16'd5, 2'd1, 16'h0022);
        write_word(16'd2, 2'd3, 16'h0033);
        route_hw = 1'b1; hw_ready = 1'b1;
        base = log_n;
        pulse_start(st);
        wait_log(base + 3, 60, "t1_delivered");
        chk("t1_v0", 64'(log_val[base]), 64'h11);
        chk("t1_v1", 64'(log_val[base+1]), 64'h22);
        chk("t1_v2", 64'(log_val[base+2]), 64'h33);
        chk("t1_ch2", 64'(log_ch[base+2]), 64'd3);
        chk("t1_gap0", 64'(log_cyc[base] - st), 64'd3);
        chk("t1_gap1", 64'(log_cyc[base+1] - log_cyc[base]), 64'd8);
        chk("t1_gap2", 64'(log_cyc[base+2] - log_cyc[base+1]), 64'd5);
        tick(4);
        chk("t1_sent", 64'(count_sent), 64'd3);
        chk("t1_underrun", 64'(underrun_count), 64'd1);
        chk("t1_level", 64'(level), 64'd0);

        // 2: fill to 8, ninth dropped, pop one, wrap-around write, drain in order
        do_reset();
        hw_ready = 1'b0;
        for (int i = 0; i < 9; i++) write_word(16'd0, 2'(i % 4), 16'(16'h0100 + i));
        chk("t2_level_full", 64'(level), 64'd8);
        chk("t2_wr_ready_full", 64'(wr_ready), 64'd0);
        chk("t2_recv", 64'(count_recv), 64'd8);
        base = log_n;
        pulse_start(st);
        wait_hw_valid(20, "t2_first_valid");
        chk("t2_first_value", 64'(hw_value), 64'h100);
        hw_ready = 1'b1;
        tick(1);
        hw_ready = 1'b0;
        chk("t2_level_pop", 64'(level), 64'd7);
        chk("t2_wr_ready_pop", 64'(wr_ready), 64'd1);
        write_word(16'd0, 2'd2, 16'h01AA);
        chk("t2_level_wrap", 64'(level), 64'd8);
        chk("t2_recv_wrap", 64'(count_recv), 64'd9);
        hw_ready = 1'b1;
        wait_log(base + 9, 100, "t2_drained");
        for (int i = 0; i < 9; i++) begin
            exp_v = (i < 8) ? 16'(16'h0100 + i) : 16'h01AA;
            chk("t2_order", 64'(log_val[base+i]), 64'(exp_v));
        end
        tick(2);
        chk("t2_sent", 64'(count_sent), 64'd9);
        chk("t2_level_empty", 64'(level), 64'd0);

        // 3: PS route, hw_ready ignored, ps_ack retires the word
        do_reset();
        route_hw = 1'b0;
        write_word(16'd0, 2'd2, 16'h0044);
        pulse_start(st);
        tick(3);
        chk("t3_ps_ready", 64'(ps_value_ready), 64'd1);
        chk("t3_ps_value", 64'(ps_value), 64'h44);
        chk("t3_ps_channel", 64'(ps_channel), 64'd2);
        chk("t3_hw_valid", 64'(hw_valid), 64'd0);
        hw_ready = 1'b1;
        tick(1);
        hw_ready = 1'b0;
        tick(1);
        chk("t3_ready_held", 64'(ps_value_ready), 64'd1);
        chk("t3_sent_held", 64'(count_sent), 64'd0);
        ps_ack = 1'b1;
        tick(1);
        ps_ack = 1'b0;
        chk("t3_ready_clr", 64'(ps_value_ready), 64'd0);
        chk("t3_sent", 64'(count_sent), 64'd1);

        // 4: refill interrupt, clear and 50-cycle hold-off
        do_reset();
        load_floor = 4'd2;
        for (int i = 0; i < 4; i++) write_word(16'd0, 2'd0, 16'(i + 1));
        chk("t4_irq_idle", 64'(refill_irq), 64'd0);
        pulse_start(st);
        chk("t4_irq_start", 64'(refill_irq), 64'd1);
        refill_clr = 1'b1;
        tick(1);
        refill_clr = 1'b0;
        chk("t4_irq_clr", 64'(refill_irq), 64'd0);
        tick(60);
        chk("t4_irq_above", 64'(refill_irq), 64'd0);
        chk("t4_level4", 64'(level), 64'd4);
        hw_ready = 1'b1;
        k = 0;
        while (level != 4'd2 && k < 40) begin tick(1); k++; end
        hw_ready = 1'b0;
        chk("t4_level2", 64'(level), 64'd2);
        chk("t4_irq_before", 64'(refill_irq), 64'd0);
        tick(1);
        chk("t4_irq_rise", 64'(refill_irq), 64'd1);
        refill_clr = 1'b1;
        tick(1);
        refill_clr = 1'b0;
        highs = 0;
        if (refill_irq) highs++;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (refill_irq) highs++;
        end
        chk("t4_holdoff", 64'(highs), 64'd0);
        tick(1);
        chk("t4_irq_reassert", 64'(refill_irq), 64'd1);

        // 5: stop during WAIT of word 2, then replay with full delay
        do_reset();
        hw_ready = 1'b1;
        write_word(16'd0, 2'd0, 16'h0055);
        write_word(16'd6, 2'd1, 16'h0066);
        base = log_n;
        pulse_start(st);
        tick(6);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("t5_valid_low", 64'(hw_valid), 64'd0);
        chk("t5_level", 64'(level), 64'd1);
        chk("t5_sent", 64'(count_sent), 64'd1);
        tick(15);
        chk("t5_no_delivery", 64'(log_n - base), 64'd1);
        pulse_start(st2);
        wait_log(base + 2, 40, "t5_replayed");
        chk("t5_value", 64'(log_val[base+1]), 64'h66);
        chk("t5_delay", 64'(log_cyc[base+1] - st2), 64'd9);

        // 6: reset while presenting
        do_reset();
        hw_ready = 1'b0;
        write_word(16'd0, 2'd1, 16'h0077);
        pulse_start(st);
        wait_hw_valid(20, "t6_valid");
        chk("t6_value", 64'(hw_value), 64'h77);
        rst_n = 1'b0;
        tick(1);
        chk("t6_hw_valid", 64'(hw_valid), 64'd0);
        chk("t6_wr_ready", 64'(wr_ready), 64'd1);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_recv", 64'(count_recv), 64'd0);
        chk("t6_value_rst", 64'(hw_value), 64'd0);
        chk("t6_irq", 64'(refill_irq), 64'd0);
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
